cmp_arbiter: RTL and testbench
==============================

# cmp_arbiter

Shares the single `cmp` comparator among `NUM_REQ` requesters, e.g. EX-stage branch resolution and ALU `slt`/`sltu`. Each cycle, a round-robin arbiter grants at most one request and feeds its `cmpop`/operands to an internal `cmp`. The 1-bit outcome is captured in a registered response slot tagged with the requester index, held under valid/ready backpressure until the consumer takes it.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8).
- `ID_W`, `$clog2(NUM_REQ)`, width of the response tag; forced to at least 1.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_op`  in  NUM_REQ × `branch_funct3_t`  compare op per requester.
- `req_a`, `req_b`  in  NUM_REQ × `rv32i_word`  operands per requester.
- `resp_valid`  out  1  response slot holds a result.
- `resp_enable`  out  1  compare outcome (1 = true / branch taken / less-than).
- `resp_id`  out  ID_W  index of the requester that produced the result.
- `resp_ready`  in  1  consumer accepts the response this cycle.

## Operation
- **Slot state:** `EMPTY` (`resp_valid`=0) or `FULL` (`resp_valid`=1).
- **Slot free this cycle:** `free = !resp_valid || resp_ready`.
- **Grant:**
  - Combinational round-robin over `req_valid`.
  - Search starts at pointer `rr`, ascending with wrap; first asserted index wins.
  - Grant is issued only when `free`.
  - `req_ready[i]` = grant to `i`.
- **Accept** (`req_valid[i] && req_ready[i]`):
  - Drive `cmp` with `req_op[i]`, `req_a[i]`, `req_b[i]`.
  - Next edge: `resp_enable` ← `cmp.enable`, `resp_id` ← `i`, `resp_valid` ← 1.
  - `rr` ← `(i+1) mod NUM_REQ`.
- **No accept:**
  - If `resp_ready` and slot FULL, `resp_valid` ← 0; `resp_enable`/`resp_id` hold their values.
  - `rr` is unchanged.
- **Simultaneous drain and accept:** the slot is overwritten with the new result and `resp_valid` stays 1. Full throughput is one compare per cycle.
- **Requester rule:** once `req_valid[i]` is asserted, it and its payload stay stable until accepted. The arbiter does not check this.
- **Comparator semantics** (from `cmp`): `beq`/`bne` equality; `blt`/`bge`/`slt` signed; `bltu`/`bgeu`/`sltu` unsigned. All funct3 encodings are defined.
- **Reset:**
  - `resp_valid`=0, `resp_enable`=0, `resp_id`=0, `rr`=0.
  - `req_ready` goes low immediately because it depends only on current state.
  - Reset mid-operation discards a held result; it is never replayed.

## Timing
- Request accepted in cycle N → `resp_valid` high in N+1, with the result valid in the same cycle.
- `req_ready` is combinational from `req_valid`, `resp_valid`, `resp_ready` and `rr`.
- There is no combinational path from `req_a`/`req_b` to any output; the result is always registered.
- Backpressure: while FULL and `resp_ready`=0, every `req_ready` is 0 and the slot holds its value unchanged.
- Starvation bound: a continuously valid requester is granted within `NUM_REQ` accepts.
- `NUM_REQ`=1 degenerates to a registered pass-through with `resp_id`=0.

## Structure
- Types `branch_funct3_t` and `rv32i_word` come from `rv32i_types`. No new package types are required.
- One sub-module: existing `cmp`, instantiated once, fed by the grant mux.
- Round-robin select stays inline as a `for` loop. It does not justify a separate module.

## Test plan
- **Single request:** requester 0 sends `blt`, a=`32'hFFFF_FFFF`, b=1, `resp_ready`=1.
  - `req_ready[0]`=1 in N.
  - In N+1: `resp_valid`=1, `resp_enable`=1, `resp_id`=0.
  - Same operands with `bltu` → `resp_enable`=0.
- **Contention:** both requesters valid every cycle; req0 `beq` 5/5, req1 `bge` 3/7; `resp_ready`=1.
  - Grants alternate 0,1,0,1 starting from 0 after reset.
  - Responses alternate `enable` 1,0 with matching `resp_id`.
- **Backpressure:** `resp_ready`=0 after the first result.
  - Slot holds value and id.
  - Both `req_ready`=0 for 3 cycles.
  - Raising `resp_ready` drains and accepts the next request in the same cycle.
- **Back-to-back throughput:** 8 consecutive `sltu` requests from requester 1 with `resp_ready`=1.
  - 8 responses in 8 consecutive cycles, no bubbles.
- **Reset mid-operation:** assert `rst` asynchronously while FULL and requests pending.
  - Outputs go to 0 before the next clock edge.
  - After release, the first grant goes to requester 0.
- **Sweep:** all 8 funct3 ops against operand pairs (0,0), (`32'h8000_0000`,1), (1,`32'h8000_0000`).
  - Each `resp_enable` matches a reference model.

Source files
------------

// File: rtl/cmp_arbiter_pkg.sv
// cmp_arbiter_pkg: RV32I compare-op and word types shared by the arbiter, its comparator and its bus.
package cmp_arbiter_pkg;
    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        slt  = 3'b010,
        sltu = 3'b011,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;
    typedef logic [31:0] rv32i_word;
endpackage

// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if: requester-side and response-side signals of the shared comparator.
interface cmp_arbiter_if
    import cmp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    branch_funct3_t     req_op [NUM_REQ];
    rv32i_word          req_a [NUM_REQ];
    rv32i_word          req_b [NUM_REQ];
    logic               resp_valid;
    logic               resp_enable;
    logic [ID_W-1:0]    resp_id;
    logic               resp_ready;
    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_enable, resp_id
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_enable, resp_id
    );
endinterface

// File: rtl/cmp_arbiter_cmp.sv
// cmp: RV32I branch / set-less-than comparator.
module cmp
    import cmp_arbiter_pkg::*;
(
    input  branch_funct3_t cmpop,
    input  rv32i_word      a,
    input  rv32i_word      b,
    output logic           enable
);
    logic eq, lt, ltu;
    assign eq  = a == b;
    assign lt  = $signed(a) < $signed(b);
    assign ltu = a < b;
    // funct3[0] inverts the branch forms; slt/sltu (01x) use it as the unsigned select
    assign enable = cmpop[2] ? ((cmpop[1] ? ltu : lt) ^ cmpop[0])
                  : cmpop[1] ? (cmpop[0] ? ltu : lt)
                  : (eq ^ cmpop[0]);
endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin sharing of one comparator with a registered, backpressured response slot.
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input logic          clk,
    input logic          rst,
    cmp_arbiter_if.slave bus
);
    logic [ID_W-1:0] rr, sel, idx;
    logic hit, free, accept, enable;
    assign free   = !rst && (!bus.resp_valid || bus.resp_ready);
    assign accept = hit && free;
    // walk downward so the valid index closest to rr is the last one written
    always_comb begin
        sel = '0;
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                sel = idx;
                hit = 1'b1;
            end
        end
    end
    assign bus.req_ready = accept ? NUM_REQ'(1) << sel : '0;
    cmp u_cmp (
        .cmpop  (bus.req_op[sel]),
        .a      (bus.req_a[sel]),
        .b      (bus.req_b[sel]),
        .enable (enable)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.resp_valid  <= 1'b0;
            bus.resp_enable <= 1'b0;
            bus.resp_id     <= '0;
            rr              <= '0;
        end else if (accept) begin
            bus.resp_valid  <= 1'b1;
            bus.resp_enable <= enable;
            bus.resp_id     <= sel;
            rr              <= ID_W'((int'(sel) + 1) % NUM_REQ);
        end else if (bus.resp_ready) begin
            bus.resp_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed scenarios plus a grant/response scoreboard for cmp_arbiter.
module tb_cmp_arbiter;
    import cmp_arbiter_pkg::*;
    localparam int N = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    cmp_arbiter_if #(.NUM_REQ(N)) bus ();
    cmp_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_cmp(input branch_funct3_t op, input rv32i_word a, input rv32i_word b);
        case (op)
            beq:       return a == b;
            bne:       return a != b;
            slt, blt:  return $signed(a) < $signed(b);
            bge:       return $signed(a) >= $signed(b);
            sltu, bltu: return a < b;
            default:   return a >= b;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [0:0] i, input branch_funct3_t op, input rv32i_word a, input rv32i_word b);
        bus.req_op[i] = op;
        bus.req_a[i]  = a;
        bus.req_b[i]  = b;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.req_valid = '0;
        tick;
        rst = 1'b0;
    endtask

    // scoreboard: model of slot occupancy and rr pointer, expected {id, enable} queued on each grant
    logic        m_full = 1'b0;
    int          m_rr = 0;
    logic [1:0]  sb[$];
    logic [N-1:0] exp_gnt;
    logic [0:0]  j, g;
    logic        hit, free;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            m_full = 1'b0;
            m_rr = 0;
            sb.delete();
        end else begin
            free = !m_full || bus.resp_ready;
            hit = 1'b0;
            g = '0;
            for (int k = 0; k < N; k++) begin
                j = 1'((m_rr + k) % N);
                if (!hit && bus.req_valid[j]) begin
                    hit = 1'b1;
                    g = j;
                end
            end
            exp_gnt = (hit && free) ? N'(1) << g : '0;
            check("req_ready", bus.req_ready, exp_gnt);
            check("resp_valid", bus.resp_valid, m_full);
            if (m_full) begin
                check("sb_depth", sb.size(), 1);
                if (sb.size() > 0) begin
                    check("sb_resp_id", bus.resp_id, sb[0][1]);
                    check("sb_resp_enable", bus.resp_enable, sb[0][0]);
                    if (bus.resp_ready) void'(sb.pop_front());
                end
            end
            if (hit && free) begin
                sb.push_back({g, ref_cmp(bus.req_op[g], bus.req_a[g], bus.req_b[g])});
                m_full = 1'b1;
                m_rr = (int'(g) + 1) % N;
            end else if (bus.resp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    int cnt;
    rv32i_word sa, sb_op;
    initial begin
        bus.req_valid = 2'b11;
        bus.resp_ready = 1'b0;
        set_req(1'b0, beq, 0, 0);
        set_req(1'b1, beq, 0, 0);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_enable", bus.resp_enable, 0);
        check("rst_resp_id", bus.resp_id, 0);
        do_reset;

        // single request: blt signed -1 < 1, then bltu unsigned
        bus.resp_ready = 1'b1;
        set_req(1'b0, blt, 32'hFFFF_FFFF, 1);
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("single_ready", bus.req_ready, 2'b01);
        tick;
        set_req(1'b0, bltu, 32'hFFFF_FFFF, 1);
        @(negedge clk);
        check("blt_valid", bus.resp_valid, 1);
        check("blt_enable", bus.resp_enable, 1);
        check("blt_id", bus.resp_id, 0);
        check("bltu_ready", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("bltu_enable", bus.resp_enable, 0);
        check("bltu_id", bus.resp_id, 0);
        tick;

        // contention: alternating grants from 0 after reset
        do_reset;
        set_req(1'b0, beq, 5, 5);
        set_req(1'b1, bge, 3, 7);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("cont_gnt", bus.req_ready, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) begin
                check("cont_id", bus.resp_id, (k - 1) % 2);
                check("cont_enable", bus.resp_enable, ((k - 1) % 2) == 0);
            end
            tick;
        end

        // backpressure: slot holds, no grants, then drain and accept together
        do_reset;
        bus.resp_ready = 1'b0;
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("bp_first_gnt", bus.req_ready, 2'b01);
        tick;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready", bus.req_ready, 2'b00);
            check("bp_valid", bus.resp_valid, 1);
            check("bp_id", bus.resp_id, 0);
            check("bp_enable", bus.resp_enable, 1);
            tick;
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_gnt", bus.req_ready, 2'b10);
        tick;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("bp_next_id", bus.resp_id, 1);
        check("bp_next_enable", bus.resp_enable, 0);
        tick;

        // back-to-back sltu from requester 1
        cnt = 0;
        bus.req_valid = 2'b10;
        for (int k = 0; k < 8; k++) begin
            set_req(1'b1, sltu, k, 4);
            @(negedge clk);
            if (k > 0 && bus.resp_valid) cnt++;
            tick;
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        if (bus.resp_valid) cnt++;
        check("b2b_count", cnt, 8);
        tick;

        // reset while FULL with requests pending
        bus.resp_ready = 1'b0;
        set_req(1'b1, beq, 5, 5);
        set_req(1'b0, beq, 5, 5);
        bus.req_valid = 2'b10;
        @(negedge clk);
        tick;
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("mid_full_id", bus.resp_id, 1);
        check("mid_full_enable", bus.resp_enable, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.resp_valid, 0);
        check("mid_rst_enable", bus.resp_enable, 0);
        check("mid_rst_id", bus.resp_id, 0);
        check("mid_rst_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_gnt", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b00;
        tick;
        tick;

        // sweep every funct3 over three operand pairs
        bus.req_valid = 2'b01;
        for (int o = 0; o < 8; o++) begin
            for (int p = 0; p < 3; p++) begin
                sa    = (p == 0) ? 32'h0 : (p == 1) ? 32'h8000_0000 : 32'h1;
                sb_op = (p == 0) ? 32'h0 : (p == 1) ? 32'h1 : 32'h8000_0000;
                set_req(1'b0, branch_funct3_t'(3'(o)), sa, sb_op);
                tick;
            end
        end
        bus.req_valid = 2'b00;
        tick;
        tick;
        @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
